// File: rtl/mem_wr_bank_pkg.sv
// Shared definitions for the operand register bank write side.
// Address map and load FSM encoding, common with the read mux.
package mem_wr_bank_pkg;

  localparam int WIDTH = 40;
  localparam int DEPTH = 64;
  localparam int AW    = 7;
  localparam int IW    = $clog2(DEPTH);

  localparam logic [AW-1:0] A_C_ADDR = 7'd64;
  localparam logic [AW-1:0] C_C_ADDR = 7'd65;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } ld_state_e;

  function automatic logic in_bank(input logic [AW-1:0] a);
    return a < AW'(DEPTH);
  endfunction

endpackage

// File: rtl/mem_load_ctrl.sv
// Bulk-load sequencer: FSM, wrapping pointer, beat counter
// and the valid/ready stream handshake.
import mem_wr_bank_pkg::*;

module mem_load_ctrl (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_start_i,
  input  logic [AW-1:0]    load_base_i,
  input  logic [AW-1:0]    load_len_i,
  input  logic             load_valid_i,
  input  logic [WIDTH-1:0] load_data_i,
  output logic             ld_we_o,
  output logic [IW-1:0]    ld_addr_o,
  output logic [WIDTH-1:0] ld_data_o,
  output logic             start_err_o,
  output logic             load_ready_o,
  output logic             load_busy_o,
  output logic             load_done_o
);

  ld_state_e     state_q;
  logic [IW-1:0] ptr_q;
  logic [AW-1:0] cnt_q;
  logic          ready_q;
  logic          busy_q;
  logic          done_q;
  logic          idle;
  logic          beat;

  assign idle = (state_q == ST_IDLE);
  assign beat = load_valid_i & ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (load_start_i && in_bank(load_base_i)) begin
            if (load_len_i == '0) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_LOAD;
              ptr_q   <= load_base_i[IW-1:0];
              cnt_q   <= load_len_i;
              ready_q <= 1'b1;
              busy_q  <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (beat) begin
            // pointer is IW bits wide, so it wraps DEPTH-1 -> 0
            ptr_q <= ptr_q + IW'(1);
            cnt_q <= cnt_q - AW'(1);
            if (cnt_q == AW'(1)) begin
              state_q <= ST_DONE;
              ready_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ld_we_o      = beat;
  assign ld_addr_o    = ptr_q;
  assign ld_data_o    = load_data_i;
  assign start_err_o  = idle & load_start_i & ~in_bank(load_base_i);
  assign load_ready_o = ready_q;
  assign load_busy_o  = busy_q;
  assign load_done_o  = done_q;

endmodule

// File: rtl/mem_wr_bank.sv
// Operand register file write side: 64 general words plus the
// a_c / c_c constants, single-word writes and streamed bulk load.
import mem_wr_bank_pkg::*;

module mem_wr_bank (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   load_start,
  input  logic [AW-1:0]          load_base,
  input  logic [AW-1:0]          load_len,
  input  logic                   load_valid,
  input  logic [WIDTH-1:0]       load_data,
  output logic                   load_ready,
  output logic                   load_busy,
  output logic                   load_done,
  output logic                   wr_err,
  output logic [DEPTH*WIDTH-1:0] mem_flat,
  output logic [WIDTH-1:0]       mem_a_c,
  output logic [WIDTH-1:0]       mem_c_c
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] ac_q;
  logic [WIDTH-1:0] cc_q;
  logic             wr_err_q;
  logic             wr_err_d;

  logic             ld_we;
  logic [IW-1:0]    ld_addr;
  logic [WIDTH-1:0] ld_data;
  logic             start_err;

  logic             sw_ok;
  logic             sw_gen;
  logic             sw_ac;
  logic             sw_cc;
  logic             mem_we;
  logic [IW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_data;

  mem_load_ctrl u_ctrl (
    .clk          (clk),
    .rst          (rst),
    .load_start_i (load_start),
    .load_base_i  (load_base),
    .load_len_i   (load_len),
    .load_valid_i (load_valid),
    .load_data_i  (load_data),
    .ld_we_o      (ld_we),
    .ld_addr_o    (ld_addr),
    .ld_data_o    (ld_data),
    .start_err_o  (start_err),
    .load_ready_o (load_ready),
    .load_busy_o  (load_busy),
    .load_done_o  (load_done)
  );

  // single writes are locked out only while a stream is active
  assign sw_ok  = wr_en & ~load_busy;
  assign sw_gen = sw_ok & in_bank(wr_addr);
  assign sw_ac  = sw_ok & (wr_addr == A_C_ADDR);
  assign sw_cc  = sw_ok & (wr_addr == C_C_ADDR);

  // the two sources never overlap: loads only in LOAD, singles never
  assign mem_we   = ld_we | sw_gen;
  assign mem_addr = ld_we ? ld_addr : wr_addr[IW-1:0];
  assign mem_data = ld_we ? ld_data : wr_data;

  always_comb begin
    wr_err_d = start_err;
    if (wr_en && (load_busy || !(in_bank(wr_addr) || sw_ac || sw_cc)))
      wr_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[mem_addr] <= mem_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ac_q     <= '0;
      cc_q     <= '0;
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_err_d;
      if (sw_ac) ac_q <= wr_data;
      if (sw_cc) cc_q <= wr_data;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign mem_flat[g*WIDTH +: WIDTH] = mem_q[g];
  end

  assign mem_a_c = ac_q;
  assign mem_c_c = cc_q;
  assign wr_err  = wr_err_q;

endmodule

// File: tb/tb_mem_wr_bank.sv
// Directed bench for mem_wr_bank: table of single writes plus
// hand-written bulk-load, error and reset-abort sequences.
module tb_mem_wr_bank;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_en;
  logic [6:0]    wr_addr;
  logic [39:0]   wr_data;
  logic          load_start;
  logic [6:0]    load_base;
  logic [6:0]    load_len;
  logic          load_valid;
  logic [39:0]   load_data;
  logic          load_ready;
  logic          load_busy;
  logic          load_done;
  logic          wr_err;
  logic [2559:0] mem_flat;
  logic [39:0]   mem_a_c;
  logic [39:0]   mem_c_c;

  int checks = 0;
  int failures = 0;

  logic [39:0] model [64];
  logic [39:0] m_ac;
  logic [39:0] m_cc;

  typedef struct {
    logic [6:0]  addr;
    logic [39:0] data;
    logic        exp_err;
    int          sel;
    int          idx;
    logic [39:0] exp_val;
  } wvec_t;

  wvec_t vecs [7];

  mem_wr_bank dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .load_start (load_start),
    .load_base  (load_base),
    .load_len   (load_len),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .wr_err     (wr_err),
    .mem_flat   (mem_flat),
    .mem_a_c    (mem_a_c),
    .mem_c_c    (mem_c_c)
  );

  always #5 clk = ~clk;

  function automatic logic [39:0] ent(input int i);
    return mem_flat[i*40 +: 40];
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm);
    int bad;
    bad = 0;
    for (int i = 0; i < 64; i++)
      if (ent(i) !== model[i]) bad++;
    chk({nm, "_entries_bad"}, bad, 0);
    chk({nm, "_a_c"}, mem_a_c, m_ac);
    chk({nm, "_c_c"}, mem_c_c, m_cc);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) model[i] = '0;
    m_ac = '0;
    m_cc = '0;
  endtask

  task automatic beat(input logic [39:0] d, input int idx);
    chk("beat_ready_pre", load_ready, 1);
    load_valid = 1'b1;
    load_data  = d;
    model[idx] = d;
    tick();
    load_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{7'd5,   40'h12_3456_789A, 1'b0, 0, 5,  40'h12_3456_789A};
    vecs[1] = '{7'd64,  40'hAAAA,         1'b0, 1, 0,  40'hAAAA};
    vecs[2] = '{7'd65,  40'h5555,         1'b0, 2, 0,  40'h5555};
    vecs[3] = '{7'd66,  40'h1,            1'b1, 1, 0,  40'hAAAA};
    vecs[4] = '{7'd63,  40'hFF_FFFF_FFFF, 1'b0, 0, 63, 40'hFF_FFFF_FFFF};
    vecs[5] = '{7'd0,   40'h1,            1'b0, 0, 0,  40'h1};
    vecs[6] = '{7'd127, 40'h7,            1'b1, 2, 0,  40'h5555};

    rst = 1'b1; wr_en = 0; wr_addr = 0; wr_data = 0;
    load_start = 0; load_base = 0; load_len = 0;
    load_valid = 0; load_data = 0;
    clear_model();
    tick(); tick();
    chk("rst_flat", (mem_flat == '0), 1);
    chk("rst_ac", mem_a_c, 0);
    chk("rst_ready", load_ready, 0);
    chk("rst_busy", load_busy, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", wr_err, 0);
    rst = 1'b0;
    tick();

    // table of single writes, applied back to back
    for (int v = 0; v < 7; v++) begin
      wr_en = 1'b1;
      wr_addr = vecs[v].addr;
      wr_data = vecs[v].data;
      if (!vecs[v].exp_err) begin
        if (vecs[v].addr < 64) model[vecs[v].addr] = vecs[v].data;
        else if (vecs[v].addr == 64) m_ac = vecs[v].data;
        else m_cc = vecs[v].data;
      end
      tick();
      chk($sformatf("vec%0d_err", v), wr_err, vecs[v].exp_err);
      case (vecs[v].sel)
        0: chk($sformatf("vec%0d_ent", v), ent(vecs[v].idx),
               vecs[v].exp_val);
        1: chk($sformatf("vec%0d_ac", v), mem_a_c, vecs[v].exp_val);
        default: chk($sformatf("vec%0d_cc", v), mem_c_c,
                     vecs[v].exp_val);
      endcase
    end
    wr_en = 1'b0;
    tick();
    chk("err_pulse_end", wr_err, 0);
    chk_all("after_table");

    // load base 62 len 4, two stall cycles mid-stream
    load_start = 1'b1; load_base = 7'd62; load_len = 7'd4;
    tick();
    load_start = 1'b0;
    chk("ld1_busy", load_busy, 1);
    chk("ld1_ready", load_ready, 1);
    beat(40'd1, 62);
    beat(40'd2, 63);
    for (int s = 0; s < 2; s++) begin
      tick();
      chk($sformatf("ld1_stall%0d_busy", s), load_busy, 1);
      chk($sformatf("ld1_stall%0d_done", s), load_done, 0);
    end
    chk("ld1_stall_ent0", ent(0), 40'h1);
    beat(40'd3, 0);
    chk("ld1_done_early", load_done, 0);
    beat(40'd4, 1);
    chk("ld1_done", load_done, 1);
    chk("ld1_busy_off", load_busy, 0);
    chk("ld1_ready_off", load_ready, 0);
    tick();
    chk("ld1_done_pulse", load_done, 0);
    chk_all("ld1");

    // single write during LOAD is rejected; load_start ignored
    load_start = 1'b1; load_base = 7'd20; load_len = 7'd2;
    tick();
    load_start = 1'b0;
    wr_en = 1'b1; wr_addr = 7'd10; wr_data = 40'hBEEF;
    tick();
    wr_en = 1'b0;
    chk("ld2_wr_err", wr_err, 1);
    chk("ld2_ent10", ent(10), 0);
    load_start = 1'b1; load_base = 7'd0; load_len = 7'd1;
    beat(40'hA1, 20);
    chk("ld2_err_pulse", wr_err, 0);
    beat(40'hA2, 21);
    load_start = 1'b0;
    chk("ld2_done", load_done, 1);
    tick();
    chk("ld2_idle_busy", load_busy, 0);
    chk_all("ld2");

    // zero-length load and out-of-range base
    load_start = 1'b1; load_base = 7'd3; load_len = 7'd0;
    tick();
    load_start = 1'b0;
    chk("len0_done", load_done, 1);
    chk("len0_busy", load_busy, 0);
    tick();
    chk("len0_done_pulse", load_done, 0);
    load_start = 1'b1; load_base = 7'd70; load_len = 7'd3;
    tick();
    load_start = 1'b0;
    chk("base70_err", wr_err, 1);
    chk("base70_busy", load_busy, 0);
    tick();
    chk("base70_err_pulse", wr_err, 0);
    chk("base70_busy2", load_busy, 0);
    chk_all("errs");

    // single write and load start in the same cycle
    wr_en = 1'b1; wr_addr = 7'd30; wr_data = 40'h77;
    load_start = 1'b1; load_base = 7'd40; load_len = 7'd1;
    model[30] = 40'h77;
    tick();
    wr_en = 1'b0; load_start = 1'b0;
    chk("both_ent30", ent(30), 40'h77);
    chk("both_busy", load_busy, 1);
    chk("both_err", wr_err, 0);
    beat(40'hC0DE, 40);
    chk("both_done", load_done, 1);
    // a write during DONE is accepted
    wr_en = 1'b1; wr_addr = 7'd31; wr_data = 40'h99;
    model[31] = 40'h99;
    tick();
    wr_en = 1'b0;
    chk("done_wr_err", wr_err, 0);
    chk_all("both");

    // reset aborts a load after 2 of 5 beats
    load_start = 1'b1; load_base = 7'd8; load_len = 7'd5;
    tick();
    load_start = 1'b0;
    beat(40'h11, 8);
    beat(40'h22, 9);
    rst = 1'b1;
    #1;
    clear_model();
    chk("abort_flat", (mem_flat == '0), 1);
    chk("abort_busy", load_busy, 0);
    chk("abort_ready", load_ready, 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("abort_done%0d", c), load_done, 0);
    end
    rst = 1'b0;
    tick();
    chk("abort_done_after", load_done, 0);
    chk("abort_busy_after", load_busy, 0);
    load_start = 1'b1; load_base = 7'd8; load_len = 7'd2;
    tick();
    load_start = 1'b0;
    beat(40'h33, 8);
    beat(40'h44, 9);
    chk("reload_done", load_done, 1);
    tick();
    chk_all("reload");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/mem_wr_bank.md
Name: mem_wr_bank

Overview:
- Write-side counterpart of the operand read multiplexer: owns the 64-entry x 40-bit operand register file plus the two curve-constant registers (a_c, c_c).
- Exposes all entries in parallel to the read mux.
- Accepts single-word writes from the datapath (results of the 40x40 multiplier/adder).
- Accepts a streamed bulk load of consecutive words with a valid/ready handshake, used to preload operands before a VDF/isogeny step.

Parameters:
- WIDTH, 40, word width in bits.
- DEPTH, 64, number of general registers (addresses 0..DEPTH-1).
- AW, 7, address width.
- A_C_ADDR, 64, write address of the a_c constant register.
- C_C_ADDR, 65, write address of the c_c constant register.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- wr_en  in  1  single-word write strobe.
- wr_addr  in  AW  single-word write address.
- wr_data  in  WIDTH  single-word write data.
- load_start  in  1  starts a bulk load (sampled only in IDLE).
- load_base  in  AW  first address of the bulk load; must be 0..DEPTH-1.
- load_len  in  AW  number of words to load (0..DEPTH).
- load_valid  in  1  stream word valid.
- load_data  in  WIDTH  stream word.
- load_ready  out  1  bank accepts a stream word this cycle.
- load_busy  out  1  bulk load in progress.
- load_done  out  1  one-cycle pulse after the last word is written.
- wr_err  out  1  one-cycle pulse on a rejected request.
- mem_flat  out  DEPTH*WIDTH  all general registers; entry i at bits [i*WIDTH +: WIDTH].
- mem_a_c  out  WIDTH  a_c register.
- mem_c_c  out  WIDTH  c_c register.

Behaviour:
- Reset (asynchronous, active-high):
  - All registers, mem_a_c and mem_c_c are cleared to 0.
  - FSM goes to IDLE.
  - load_ready, load_busy, load_done and wr_err are all 0.
  - Asserting rst mid-load aborts the load immediately; no load_done is produced.
- Single write, IDLE only:
  - wr_en with wr_addr < DEPTH updates that entry at the next rising edge; the new value is visible on mem_flat the same edge (1-cycle latency, no read-during-write bypass needed).
  - wr_addr == A_C_ADDR or C_C_ADDR updates mem_a_c or mem_c_c respectively.
  - Any other address: no write; wr_err pulses for 1 cycle.
- FSM states: IDLE, LOAD, DONE.
- IDLE:
  - load_start with load_base < DEPTH and load_len != 0 → LOAD. The pointer is loaded with load_base and the counter with load_len.
  - load_start with load_len == 0 → DONE; no writes occur.
  - load_start with load_base >= DEPTH → stay in IDLE; wr_err pulses.
  - load_start and wr_en in the same cycle: the single write is performed and the load also starts.
- LOAD:
  - load_ready = 1 and load_busy = 1.
  - Each cycle with load_valid & load_ready writes load_data to the pointer address, increments the pointer and decrements the counter.
  - The pointer wraps from DEPTH-1 to 0; constants are never written by a load.
  - When the beat that brings the counter to 0 is accepted → DONE.
  - load_valid low stalls without side effects; there is no timeout.
  - wr_en during LOAD is rejected: no write, wr_err pulses.
  - load_start during LOAD is ignored.
- DONE:
  - load_done = 1 and load_busy = 0 for exactly 1 cycle, then → IDLE.
  - wr_en during DONE is accepted as in IDLE.
- All outputs are registered. wr_err and load_done are each high for exactly 1 cycle per event.
- Load throughput: 1 word/cycle. A load of N words completes N+1 cycles after the first accepted beat, counting the DONE pulse.

Decomposition:
- Shared package holds:
  - WIDTH, DEPTH, AW;
  - the A_C_ADDR and C_C_ADDR constants (kept shared with the read mux so both sides agree on the address map);
  - the FSM state encoding (IDLE=0, LOAD=1, DONE=2, 2 bits).
- One natural sub-module: mem_load_ctrl, containing the FSM, pointer/counter and handshake. It outputs a write enable, address and data into a single arbitration point.
- The register array and the constant registers stay in mem_wr_bank.

Test Plan:
- Reset, then wr_en with addr 5, data 0x12_3456_789A → after 1 edge mem_flat[5*40+:40] = 0x123456789A; all other entries remain 0; wr_err stays 0.
- Write addr 64 = 0xAAAA, addr 65 = 0x5555, addr 66 = 0x1 → mem_a_c = 0xAAAA, mem_c_c = 0x5555; addr 66 causes no write, wr_err pulses exactly 1 cycle.
- load_start base 62, len 4, data 1,2,3,4 with load_valid deasserted for 2 cycles mid-stream → entries 62, 63, 0, 1 = 1, 2, 3, 4; load_done pulses 1 cycle after the 4th beat; mem_a_c is untouched.
- wr_en to addr 10 during LOAD → entry 10 unchanged, wr_err pulse; load continues and completes normally.
- load_start with len 0 → load_done next cycle, no register changes; load_start with base 70 → wr_err pulse, load_busy never set.
- rst asserted after 2 of 5 load beats → immediate clear of all entries, FSM in IDLE, no load_done; a new load after rst deassertion succeeds.
